// File: rtl/up_sample_buffer.sv
// up_sample_buffer: captures one input line, then replays it 2x horizontally and 2x vertically
// under a downstream pull handshake. Rev 1.0
`default_nettype none

module up_sample_buffer #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int COL_W      = 9,
   parameter int ROW_W      = 8
) (
   input  logic       clk,
   input  logic       global_reset_n,
   input  logic [7:0] data_in,
   input  logic       wr_en,
   input  logic       valid_in,
   output logic       full,
   output logic [7:0] data_out,
   output logic       valid_out,
   input  logic       rd_en,
   output logic       frame_done
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      EMIT_ROW0 = 2'd2,
      EMIT_ROW1 = 2'd3
   } state_t;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   state_t           state, state_nx;
   logic [COL_W-1:0] wr_ptr, wr_ptr_nx;
   logic [COL_W-1:0] col, col_nx;
   logic             dup, dup_nx;
   logic [ROW_W-1:0] row, row_nx;
   logic             frame_done_nx;
   logic             write_ok;
   logic             consume;
   logic [7:0]       line_buf [IMG_WIDTH];

   // Outputs decode straight from registered state so reset clears them immediately.
   assign full      = (state != FILL);
   assign valid_out = (state == EMIT_ROW0) || (state == EMIT_ROW1);
   assign data_out  = valid_out ? line_buf[col] : 8'd0;
   assign write_ok  = (state == FILL) && wr_en && valid_in;
   assign consume   = valid_out && rd_en;

   always_comb begin
      state_nx      = state;
      wr_ptr_nx     = wr_ptr;
      col_nx        = col;
      dup_nx        = dup;
      row_nx        = row;
      frame_done_nx = 1'b0;
      case (state)
         IDLE: state_nx = FILL;
         FILL: begin
            if (write_ok) begin
               if (wr_ptr == COL_LAST) begin
                  wr_ptr_nx = '0;
                  state_nx  = EMIT_ROW0;
               end else begin
                  wr_ptr_nx = wr_ptr + 1'b1;
               end
            end
         end
         EMIT_ROW0, EMIT_ROW1: begin
            if (consume) begin
               if (!dup) begin
                  dup_nx = 1'b1;
               end else begin
                  dup_nx = 1'b0;
                  if (col == COL_LAST) begin
                     col_nx = '0;
                     if (state == EMIT_ROW0) begin
                        state_nx = EMIT_ROW1;
                     end else begin
                        state_nx = FILL;
                        if (row == ROW_LAST) begin
                           row_nx        = '0;
                           frame_done_nx = 1'b1;
                        end else begin
                           row_nx = row + 1'b1;
                        end
                     end
                  end else begin
                     col_nx = col + 1'b1;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         col        <= '0;
         dup        <= 1'b0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         wr_ptr     <= wr_ptr_nx;
         col        <= col_nx;
         dup        <= dup_nx;
         row        <= row_nx;
         frame_done <= frame_done_nx;
      end
   end

   // Line storage carries no reset; stale contents are never shown before a full refill.
   always_ff @(posedge clk) begin
      if (write_ok) begin
         line_buf[wr_ptr] <= data_in;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_up_sample_buffer.sv
// tb_up_sample_buffer: randomized + directed scoreboard bench for up_sample_buffer (W=4, H=2).
`default_nettype none

module tb_up_sample_buffer;

   localparam int W = 4;
   localparam int H = 2;

   logic       clk = 1'b0;
   logic       global_reset_n = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       wr_en = 1'b0;
   logic       valid_in = 1'b0;
   logic       rd_en = 1'b0;
   logic       full;
   logic [7:0] data_out;
   logic       valid_out;
   logic       frame_done;

   int passed = 0;
   int total  = 0;

   up_sample_buffer #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .COL_W     (2),
      .ROW_W     (1)
   ) dut (
      .clk           (clk),
      .global_reset_n(global_reset_n),
      .data_in       (data_in),
      .wr_en         (wr_en),
      .valid_in      (valid_in),
      .full          (full),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .rd_en         (rd_en),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: mode 0=idle, 1=accepting a line, 2=replaying it.
   int         m_mode = 0;
   int         m_remaining = 0;
   int         m_lines = 0;
   bit         m_fd = 1'b0;
   logic [7:0] line_q[$];
   logic [7:0] exp_q[$];

   always @(posedge clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         m_mode = 0; m_remaining = 0; m_lines = 0; m_fd = 1'b0;
         line_q.delete();
         exp_q.delete();
      end else begin
         m_fd = 1'b0;
         case (m_mode)
            0: m_mode = 1;
            1: if (wr_en && valid_in) begin
                  line_q.push_back(data_in);
                  if (line_q.size() == W) begin
                     for (int r = 0; r < 2; r++)
                        for (int i = 0; i < W; i++) begin
                           exp_q.push_back(line_q[i]);
                           exp_q.push_back(line_q[i]);
                        end
                     line_q.delete();
                     m_mode = 2;
                     m_remaining = 4 * W;
                  end
               end
            default: if (rd_en) begin
                  m_remaining--;
                  if (m_remaining == 0) begin
                     m_mode = 1;
                     m_lines++;
                     if (m_lines % H == 0) m_fd = 1'b1;
                  end
               end
         endcase
      end
   end

   // Monitor: compares flags every cycle and pops the scoreboard on each consumed pixel.
   always @(negedge clk) begin
      chk("full", full, (m_mode != 1));
      chk("valid_out", valid_out, (m_mode == 2));
      chk("frame_done", frame_done, m_fd);
      if (valid_out === 1'b1 && rd_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL data_underflow: got %0h expected none at %0t", data_out, $time);
         end else begin
            chk("data_out", data_out, exp_q.pop_front());
         end
      end else if (valid_out !== 1'b1) begin
         chk("data_zero", data_out, 8'd0);
      end
   end

   task automatic cyc(input logic w, input logic v, input logic [7:0] d, input logic r);
      @(posedge clk);
      #1;
      wr_en = w; valid_in = v; data_in = d; rd_en = r;
   endtask

   task automatic write_line(input logic [7:0] base);
      for (int i = 0; i < W; i++) cyc(1'b1, 1'b1, base + 8'(16 * i), 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (!(m_mode == 1 && exp_q.size() == 0) && n < 200) begin
         cyc(1'b0, 1'b0, 8'd0, 1'b1);
         n++;
      end
      if (n >= 200) begin
         total++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   task automatic async_reset_check();
      @(posedge clk);
      #3 global_reset_n = 1'b0;
      wr_en = 1'b0; valid_in = 1'b0; rd_en = 1'b0;
      #1;
      chk("rst_full", full, 1'b1);
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_data", data_out, 8'd0);
      chk("rst_frame_done", frame_done, 1'b0);
      #12 global_reset_n = 1'b1;
   endtask

   initial begin
      #3;
      chk("init_full", full, 1'b1);
      chk("init_valid", valid_out, 1'b0);
      #20 global_reset_n = 1'b1;
      cyc(1'b0, 1'b0, 8'd0, 1'b0);

      // Basic line, continuous pull, with dropped writes during replay.
      write_line(8'h10);
      for (int i = 0; i < 18; i++) cyc(i % 3 == 0, 1'b1, 8'hFF, 1'b1);
      drain();

      // Backpressure: toggling pull.
      write_line(8'h10);
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 8'd0, i % 2 == 0);
      drain();

      // Unqualified writes are ignored.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h55, 1'b0);
      write_line(8'h03);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      drain();

      // Reset in the middle of a replay, then a fresh line.
      write_line(8'h21);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'd0, 1'b1);
      async_reset_check();
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      write_line(8'h07);
      drain();
      write_line(8'h0B);
      drain();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
